// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter (CPU on m0, debug/DMA on m1) sharing one zero-latency slave.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed m0 priority.
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic [31:0] s_writedata,
  output logic        s_read,
  output logic        s_write,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, next_state;
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      last_owner <= 1'b1;
    else if (state != OWN0 && next_state == OWN0)   last_owner <= 1'b0;
    else if (state != OWN1 && next_state == OWN1)   last_owner <= 1'b1;
  end
`endif

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          next_state = last_owner ? OWN0 : OWN1;
`else
          next_state = OWN0;
`endif
        end else if (req0) next_state = OWN0;
        else if (req1)     next_state = OWN1;
      end
      // Abandoned request or completed transfer both return to IDLE, giving a bubble cycle.
      OWN0:    if (!req0 || !s_waitrequest) next_state = IDLE;
      OWN1:    if (!req1 || !s_waitrequest) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_address      = 32'h0;
    s_writedata    = 32'h0;
    s_byteenable   = 4'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    grant          = 2'b00;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = 32'h0;
    m1_readdata    = 32'h0;
    case (state)
      OWN0: begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;  // write wins a read+write collision
        grant          = 2'b01;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      OWN1: begin
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        grant          = 2'b10;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: per-cycle vector table plus a reset-mid-transfer sequence.
module tb_mips_bus_arbiter;

  localparam logic [31:0] M0_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] M0_WDAT = 32'h1111_1111;
  localparam logic [3:0]  M0_BE   = 4'b1111;
  localparam logic [31:0] M1_ADDR = 32'h0000_1000;
  localparam logic [31:0] M1_WDAT = 32'hDEAD_BEEF;
  localparam logic [3:0]  M1_BE   = 4'b0011;
  localparam logic [31:0] S_RDAT  = 32'h2402_0005;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_writedata(s_writedata), .s_read(s_read),
    .s_write(s_write), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant)
  );

  typedef struct {
    logic       m0r, m0w, m1r, m1w, sw;
    logic [1:0] g;
    logic       srd, swr, w0, w1;
  } vec_t;

  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic m0r, m0w, m1r, m1w, sw,
                     input logic [1:0] g, input logic srd, swr, w0, w1);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.sw = sw;
    v.g = g; v.srd = srd; v.swr = swr; v.w0 = w0; v.w1 = w1;
    vq.push_back(v);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " grant"}, 64'(grant), 64'(2'b00));
    check({tag, " strobes"}, 64'({s_read, s_write}), 64'(2'b00));
    check({tag, " waits"}, 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b11));
  endtask

  initial begin
    reset = 1'b1;
    m0_address = M0_ADDR; m0_writedata = M0_WDAT; m0_byteenable = M0_BE;
    m1_address = M1_ADDR; m1_writedata = M1_WDAT; m1_byteenable = M1_BE;
    s_readdata = S_RDAT;
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest} = '0;

    //   m0r m0w m1r m1w sw   grant  srd swr w0 w1
    add(0, 0, 0, 0, 0,  2'b00, 0, 0, 1, 1);  // idle
    add(1, 0, 0, 0, 0,  2'b00, 0, 0, 1, 1);  // m0 boot read: arbitration cycle
    add(1, 0, 0, 0, 0,  2'b01, 1, 0, 0, 1);  // m0 granted, completes
    add(0, 0, 0, 0, 0,  2'b00, 0, 0, 1, 1);  // bubble
    add(0, 0, 0, 1, 1,  2'b00, 0, 0, 1, 1);  // m1 write, slave stalling
    add(0, 0, 0, 1, 1,  2'b10, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1,  2'b10, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1,  2'b10, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0,  2'b10, 0, 1, 1, 0);  // 4th cycle completes
    add(0, 0, 0, 0, 0,  2'b00, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0,  2'b00, 0, 0, 1, 1);  // simultaneous reads held
    add(1, 0, 1, 0, 0,  2'b01, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0,  2'b00, 0, 0, 1, 1);
`ifdef ARB_ROUND_ROBIN_EN
    add(1, 0, 1, 0, 0,  2'b10, 1, 0, 1, 0);
`else
    add(1, 0, 1, 0, 0,  2'b01, 1, 0, 0, 1);
`endif
    add(0, 0, 1, 0, 0,  2'b00, 0, 0, 1, 1);  // lone m1 always wins
    add(0, 0, 1, 0, 0,  2'b10, 1, 0, 1, 0);
    add(0, 0, 1, 1, 0,  2'b00, 0, 0, 1, 1);  // m1 read+write collision
    add(0, 0, 1, 1, 0,  2'b10, 0, 1, 1, 0);
    add(1, 0, 1, 0, 1,  2'b00, 0, 0, 1, 1);  // m0 wins, then abandons
    add(0, 0, 1, 0, 1,  2'b01, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1,  2'b00, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0,  2'b10, 1, 0, 1, 0);  // pending m1 served
    add(0, 0, 0, 0, 0,  2'b00, 0, 0, 1, 1);

    #2;
    check_idle("reset");
    check("reset m0_readdata", 64'(m0_readdata), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest} =
        {vq[i].m0r, vq[i].m0w, vq[i].m1r, vq[i].m1w, vq[i].sw};
      #1;
      check({tag, " grant"}, 64'(grant), 64'(vq[i].g));
      check({tag, " strobes"}, 64'({s_read, s_write}), 64'({vq[i].srd, vq[i].swr}));
      check({tag, " waits"}, 64'({m0_waitrequest, m1_waitrequest}), 64'({vq[i].w0, vq[i].w1}));
      case (vq[i].g)
        2'b01: begin
          check({tag, " s_bus"}, {s_address, s_writedata}, {M0_ADDR, M0_WDAT});
          check({tag, " s_be"}, 64'(s_byteenable), 64'(M0_BE));
          check({tag, " m0_readdata"}, 64'(m0_readdata), 64'(S_RDAT));
        end
        2'b10: begin
          check({tag, " s_bus"}, {s_address, s_writedata}, {M1_ADDR, M1_WDAT});
          check({tag, " s_be"}, 64'(s_byteenable), 64'(M1_BE));
          check({tag, " m1_readdata"}, 64'(m1_readdata), 64'(S_RDAT));
        end
        default:
          check({tag, " readdata"}, {m0_readdata, m1_readdata}, 64'h0);
      endcase
    end

    // Reset hits mid-transfer while the slave stalls: bus must release before the next edge.
    @(negedge clk);
    m0_read = 1'b1; s_waitrequest = 1'b1;
    @(negedge clk); #1;
    check("stall grant", 64'(grant), 64'(2'b01));
    check("stall s_read", 64'(s_read), 64'h1);
    #1 reset = 1'b1;
    #1;
    check_idle("async reset");
    @(negedge clk);
    reset = 1'b0; m0_read = 1'b0; s_waitrequest = 1'b0;
    @(negedge clk); #1;
    check_idle("post reset");

    // First transfer after this reset still takes the normal arbitration cycle.
    @(negedge clk);
    m0_read = 1'b1;
    #1;
    check_idle("rearb");
    @(negedge clk); #1;
    check("rearb grant", 64'(grant), 64'(2'b01));
    check("rearb m0_readdata", 64'(m0_readdata), 64'(S_RDAT));
    check("rearb m0_wait", 64'(m0_waitrequest), 64'h0);
    @(negedge clk);
    m0_read = 1'b0;
    #1;
    check_idle("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
